ripemd160_padder: RTL
=====================

# ripemd160_padder

Byte-serial message padder that sits directly upstream of the RIPEMD-160 stage-1 round core in the Hash160 datapath. It collects a 1–55-byte message, applies RIPEMD-160 MD-style padding (0x80 marker, zero fill, 64-bit little-endian bit length), and presents one 512-bit block with a single-cycle valid pulse. After each block it holds off new input long enough for the non-stalling round core to finish.

## Interface
- HOLD_CYCLES, 18, cycles `o_ready` stays low after each `o_valid` pulse; legal range 1–31. The default covers the round core's 18-cycle busy window: 1 sample, 16 rounds, 1 done.
- MAX_BYTES, 55, maximum message length in bytes. Fixed because the block is single-block only; not to be overridden.
- clk_p_i  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_valid  in  1  input byte valid.
- i_data  in  8  message byte, presented in message order.
- i_last  in  1  marks the final byte of the message; qualified by `i_valid`.
- o_ready  out  1  padder accepts a byte this cycle; a byte is accepted when `i_valid && o_ready`.
- o_valid  out  1  one-cycle pulse: `block` holds a padded block. Drives the round core's `i_valid`.
- block  out  512  padded block, registered. Message byte n sits at `block[8n+7:8n]`, so 32-bit word j is `block[32j+31:32j]`, little-endian.
- o_err  out  1  one-cycle pulse: message overlength, message dropped.

## Operation
- Registers:
  - 512-bit block buffer.
  - 6-bit byte count `cnt`.
  - 5-bit hold counter.
  - State: COLLECT, EMIT, HOLD, DRAIN.
- Reset values: `o_ready`=0 during reset and 1 once reset is released (state COLLECT); `o_valid`=0, `o_err`=0, `block`=0, `cnt`=0.
- **COLLECT** (`o_ready`=1). On an accepted byte with `cnt` < 55:
  - Write `i_data` into buffer bits `[8*cnt+7:8*cnt]`.
  - If `i_last`=0: `cnt` += 1.
  - If `i_last`=1: L = `cnt`+1. Write 0x80 at byte L and set `block[511:448]` = {55'b0, L*8 (9 bits)}. Bytes L+1..55 are already zero. Go to EMIT.
- **Overlength.** An accepted byte with `cnt`=55:
  - If `i_last`=0: byte discarded, `o_err` pulses, go to DRAIN.
  - If `i_last`=1: byte discarded, `o_err` pulses, go to COLLECT with buffer and `cnt` cleared.
- **EMIT** (`o_ready`=0). `o_valid`=1 for exactly this cycle. Load the hold counter with HOLD_CYCLES; go to HOLD.
- **HOLD** (`o_ready`=0). Decrement the counter each cycle. At 1: clear the buffer's message bytes and `cnt`, go to COLLECT.
  - The `block` output register keeps its value until the next EMIT. The internal collect buffer is separate from the output register.
- **DRAIN** (`o_ready`=1). Discard all accepted bytes. On an accepted byte with `i_last`=1: clear buffer and `cnt`, go to COLLECT. No `o_valid`, and no further `o_err`.
- Zero-length messages are not supported; every message carries at least one byte.
- `i_data` and `i_last` are ignored whenever `i_valid`=0 or `o_ready`=0.

## Timing
- Last byte accepted at edge T → `o_valid`=1 and `block` updated during cycle T+1. `block` stays stable until the next EMIT.
- `o_ready` is low from T+1 through T+1+HOLD_CYCLES and returns high at T+2+HOLD_CYCLES. With the default, the next byte is accepted no earlier than 20 cycles after the last byte.
- One byte is accepted per cycle at most. Bytes may arrive with arbitrary gaps.
- `o_err` is asserted in the cycle after the offending byte is accepted.
- Asynchronous reset mid-message or mid-HOLD:
  - The partial message is lost and all outputs return to reset values immediately.
  - The first message after reset pads with no stale bytes.

## Test plan
- "abc" (61 62 63, last on 63) → one `o_valid` pulse.
  - Word0 = 0x80636261, words 1–13 = 0, word14 = 0x00000018, word15 = 0.
- 32-byte digest 0x00..0x1f → word0 = 0x03020100, word7 = 0x1f1e1d1c, word8 = 0x00000080, word14 = 0x00000100.
- 55 bytes of 0xAA → word13 = 0x80AAAAAA, word14 = 0x000001B8. No `o_err`.
- 56 bytes of 0x55, then message "a":
  - `o_err` pulses once, one cycle after the 56th byte; no `o_valid` for that message.
  - "a" yields word0 = 0x00008061, word14 = 0x00000008, and no leftover 0x55 bytes.
- Back-to-back messages with `i_valid` held high → `o_ready` is low for exactly 18 cycles after each `o_valid`. No byte is accepted during HOLD, and `block` is unchanged during HOLD.
- Reset asserted after 10 bytes of 0xFF, then "abc" → during reset `o_valid`=0, `o_err`=0, `block`=0; after reset the block matches the first scenario exactly.

Source files
------------

// File: rtl/ripemd160_padder.sv
// RIPEMD-160 single-block message padder.
// Collects 1-55 bytes, pads, emits one 512-bit block, then holds off input.
module ripemd160_padder #(
    parameter int HOLD_CYCLES = 18,
    parameter int MAX_BYTES   = 55
) (
    input  logic         clk_p_i,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [7:0]   i_data,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_valid,
    output logic [511:0] block,
    output logic         o_err
);

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        HOLD,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [8*MAX_BYTES-1:0] msg;
    logic [5:0]             cnt;
    logic [4:0]             hold;
    logic                   accept;
    logic                   full;
    logic [8:0]             pos;
    logic [8:0]             len_bits;
    logic [511:0]           pad;

    assign accept   = i_valid && o_ready;
    assign full     = (cnt == 6'(MAX_BYTES));
    assign pos      = {cnt, 3'b000};
    // Bit length of the message also equals the bit offset of the 0x80 marker.
    assign len_bits = {cnt + 6'd1, 3'b000};

    // Ready only outside reset, so the upstream never sees a phantom slot.
    assign o_ready = rst_n && ((state == COLLECT) || (state == DRAIN));
    assign o_valid = (state == EMIT);

    // Padded block as it would look if the current byte is the last one.
    always_comb begin
        pad                    = '0;
        pad[8*MAX_BYTES-1:0]   = msg;
        pad[pos +: 8]          = i_data;
        pad[len_bits +: 8]     = 8'h80;
        pad[511:448]           = {55'b0, len_bits};
    end

    // State register.
    always_ff @(posedge clk_p_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    if (full) begin
                        state_nxt = i_last ? COLLECT : DRAIN;
                    end else if (i_last) begin
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: state_nxt = HOLD;
            HOLD: begin
                if (hold == 5'd1) begin
                    state_nxt = COLLECT;
                end
            end
            DRAIN: begin
                if (accept && i_last) begin
                    state_nxt = COLLECT;
                end
            end
        endcase
    end

    // Collect buffer, byte count, hold timer, output block and error pulse.
    always_ff @(posedge clk_p_i or negedge rst_n) begin
        if (!rst_n) begin
            msg   <= '0;
            cnt   <= '0;
            hold  <= '0;
            block <= '0;
            o_err <= 1'b0;
        end else begin
            o_err <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (full) begin
                            o_err <= 1'b1;
                            msg   <= '0;
                            cnt   <= '0;
                        end else if (i_last) begin
                            block <= pad;
                        end else begin
                            msg[pos +: 8] <= i_data;
                            cnt           <= cnt + 6'd1;
                        end
                    end
                end
                EMIT: hold <= 5'(HOLD_CYCLES);
                HOLD: begin
                    hold <= hold - 5'd1;
                    if (hold == 5'd1) begin
                        msg <= '0;
                        cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (accept && i_last) begin
                        msg <= '0;
                        cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
